serial_link_flit_tx: RTL

Transmit-side data-link framer of the serial link. It consumes the AXI-Stream payloads emitted by the protocol layer (one payload = one credited packet) and slices each into a header flit plus a fixed number of data flits for the physical layer. Flow control on both sides is valid/ready. Credits are not touched; they travel inside the payload.

---
 rtl/serial_link_flit_tx.sv | 139 +++++++++++++
 1 files changed

// File: rtl/serial_link_flit_tx.sv
// Transmit-side flit framer: slices each accepted payload into one header flit
// followed by NumFlits data flits, with valid/ready flow control on both sides.
//
//   state  | meaning
//   S_IDLE | no packet held, waiting for a payload
//   S_HDR  | presenting the header flit (sequence number, flit count)
//   S_DATA | presenting data flit r_idx of the captured payload
module serial_link_flit_tx #(
  parameter int PayloadWidth = 80,
  parameter int FlitWidth    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    payload_valid_i,
  output logic                    payload_ready_o,
  input  logic [PayloadWidth-1:0] payload_data_i,
  output logic                    flit_valid_o,
  input  logic                    flit_ready_i,
  output logic [FlitWidth-1:0]    flit_data_o,
  output logic                    flit_first_o,
  output logic                    flit_last_o,
  output logic [7:0]              pkt_cnt_o
);

  localparam int NumFlits = (PayloadWidth + FlitWidth - 1) / FlitWidth;
  localparam int PadWidth = NumFlits * FlitWidth;
  localparam logic [7:0] LastIdx = 8'(NumFlits - 1);

  if (NumFlits > 255 || FlitWidth < 16 || PayloadWidth < 1) begin : g_param_err
    $error("serial_link_flit_tx: illegal PayloadWidth/FlitWidth combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PayloadWidth-1:0] r_pld;
  logic [7:0]              r_seq;
  logic [7:0]              r_idx;

  logic                    w_capture;
  logic                    w_seq_inc;
  logic                    w_idx_inc;
  logic                    w_idx_clr;
  logic                    w_pld_rdy;
  logic                    w_is_last;
  logic [PadWidth-1:0]     w_pld_pad;
  logic [FlitWidth-1:0]    w_data_flit;
  logic [FlitWidth-1:0]    w_hdr_flit;

  // Zero-extension supplies the padding bits of the final data flit.
  assign w_pld_pad = PadWidth'(r_pld);
  assign w_is_last = (r_idx == LastIdx);

  always_comb begin
    w_data_flit = '0;
    for (int k = 0; k < NumFlits; k++) begin
      if (r_idx == 8'(k)) w_data_flit = w_pld_pad[k*FlitWidth +: FlitWidth];
    end
  end

  always_comb begin
    w_hdr_flit        = '0;
    w_hdr_flit[7:0]   = r_seq;
    w_hdr_flit[15:8]  = 8'(NumFlits);
  end

  always_comb begin
    w_state_nxt  = r_state;
    flit_valid_o = 1'b0;
    flit_data_o  = '0;
    flit_first_o = 1'b0;
    flit_last_o  = 1'b0;
    w_pld_rdy    = 1'b0;
    w_capture    = 1'b0;
    w_seq_inc    = 1'b0;
    w_idx_inc    = 1'b0;
    w_idx_clr    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pld_rdy = 1'b1;
        if (payload_valid_i) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HDR;
        end
      end
      S_HDR: begin
        flit_valid_o = 1'b1;
        flit_data_o  = w_hdr_flit;
        flit_first_o = 1'b1;
        if (flit_ready_i) begin
          w_seq_inc   = 1'b1;
          w_idx_clr   = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        flit_valid_o = 1'b1;
        flit_data_o  = w_data_flit;
        flit_last_o  = w_is_last;
        // Accepting the next payload on the last-flit handshake avoids a bubble.
        w_pld_rdy    = w_is_last & flit_ready_i;
        if (flit_ready_i) begin
          if (w_is_last) begin
            w_idx_clr = 1'b1;
            if (payload_valid_i) begin
              w_capture   = 1'b1;
              w_state_nxt = S_HDR;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end else begin
            w_idx_inc = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign payload_ready_o = w_pld_rdy & rst_ni;
  assign pkt_cnt_o       = r_seq;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_pld   <= '0;
      r_seq   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_pld <= payload_data_i;
      if (w_seq_inc) r_seq <= r_seq + 8'd1;
      if (w_idx_clr)      r_idx <= '0;
      else if (w_idx_inc) r_idx <= r_idx + 8'd1;
    end
  end

endmodule
